// File: rtl/input_events.sv
// Turns debounced switch/button levels into registered single-cycle events.
// Define INPUT_EVENTS_REPEAT_EN to enable hold-to-repeat; otherwise btn_repeat is tied to 0.
module input_events #(
    parameter int unsigned HOLD_CYCLES   = 50_000_000,
    parameter int unsigned REPEAT_CYCLES = 10_000_000,
    parameter int unsigned CNT_W         = 27
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] sw_in,
    input  logic [4:0] btn_in,
    output logic [7:0] sw_q,
    output logic       sw_changed,
    output logic [4:0] btn_press,
    output logic [4:0] btn_release,
    output logic [4:0] btn_repeat,
    output logic [4:0] btn_held
);

    localparam int NUM_BTN = 5;

    // Reject configurations whose terminal counts cannot be represented.
    if ((HOLD_CYCLES == 0) || (REPEAT_CYCLES == 0) || (CNT_W == 0) ||
        (64'(HOLD_CYCLES) >= (64'd1 << CNT_W)) ||
        (64'(REPEAT_CYCLES) >= (64'd1 << CNT_W))) begin : g_bad_cfg
        $error("input_events: HOLD_CYCLES/REPEAT_CYCLES do not fit in CNT_W");
    end

`ifdef INPUT_EVENTS_REPEAT_EN
    typedef enum logic [1:0] {
        ST_WAIT_LOW = 2'd0,
        ST_IDLE     = 2'd1,
        ST_HOLD     = 2'd2,
        ST_REPEAT   = 2'd3
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_WAIT_LOW = 2'd0,
        ST_IDLE     = 2'd1,
        ST_HELD     = 2'd2
    } state_e;
`endif

    // ------------------------------------------------------------------
    // Switch path
    // ------------------------------------------------------------------
    logic [7:0] sw_d;
    logic       sw_changed_q;
    logic       sw_changed_d;
    logic       primed_q;
    logic       primed_d;

    always_comb begin
        sw_d         = sw_in;
        primed_d     = 1'b1;
        sw_changed_d = primed_q && (sw_in != sw_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_q         <= '0;
            sw_changed_q <= 1'b0;
            primed_q     <= 1'b0;
        end else begin
            sw_q         <= sw_d;
            sw_changed_q <= sw_changed_d;
            primed_q     <= primed_d;
        end
    end

    assign sw_changed = sw_changed_q;

    // ------------------------------------------------------------------
    // Per-button event FSMs
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            state_e state_q;
            state_e state_d;
            logic   press_q;
            logic   press_d;
            logic   release_q;
            logic   release_d;
            logic   held_q;
            logic   held_d;
            logic   btn;

            assign btn = btn_in[gi];

`ifdef INPUT_EVENTS_REPEAT_EN
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;
            logic             repeat_q;
            logic             repeat_d;
            logic             hold_done;
            logic             rep_done;

            assign hold_done = (cnt_q == CNT_W'(HOLD_CYCLES - 1));
            assign rep_done  = (cnt_q == CNT_W'(REPEAT_CYCLES - 1));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_q   <= ST_WAIT_LOW;
                    cnt_q     <= '0;
                    press_q   <= 1'b0;
                    release_q <= 1'b0;
                    repeat_q  <= 1'b0;
                    held_q    <= 1'b0;
                end else begin
                    state_q   <= state_d;
                    cnt_q     <= cnt_d;
                    press_q   <= press_d;
                    release_q <= release_d;
                    repeat_q  <= repeat_d;
                    held_q    <= held_d;
                end
            end

            // Release takes priority over a terminal count on the same edge.
            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                case (state_q)
                    ST_WAIT_LOW: begin
                        if (!btn) state_d = ST_IDLE;
                    end
                    ST_IDLE: begin
                        if (btn) begin
                            state_d = ST_HOLD;
                            cnt_d   = '0;
                        end
                    end
                    ST_HOLD: begin
                        if (!btn) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end else if (hold_done) begin
                            state_d = ST_REPEAT;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    ST_REPEAT: begin
                        if (!btn) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end else if (rep_done) begin
                            cnt_d = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_d = ST_WAIT_LOW;
                        cnt_d   = '0;
                    end
                endcase
            end

            always_comb begin
                press_d   = (state_q == ST_IDLE) && btn;
                release_d = ((state_q == ST_HOLD) || (state_q == ST_REPEAT)) && !btn;
                repeat_d  = btn && (((state_q == ST_HOLD) && hold_done) ||
                                    ((state_q == ST_REPEAT) && rep_done));
                held_d    = (state_d == ST_HOLD) || (state_d == ST_REPEAT);
            end

            assign btn_repeat[gi] = repeat_q;
`else
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_q   <= ST_WAIT_LOW;
                    press_q   <= 1'b0;
                    release_q <= 1'b0;
                    held_q    <= 1'b0;
                end else begin
                    state_q   <= state_d;
                    press_q   <= press_d;
                    release_q <= release_d;
                    held_q    <= held_d;
                end
            end

            always_comb begin
                state_d = state_q;
                case (state_q)
                    ST_WAIT_LOW: if (!btn) state_d = ST_IDLE;
                    ST_IDLE:     if (btn)  state_d = ST_HELD;
                    ST_HELD:     if (!btn) state_d = ST_IDLE;
                    default:     state_d = ST_WAIT_LOW;
                endcase
            end

            always_comb begin
                press_d   = (state_q == ST_IDLE) && btn;
                release_d = (state_q == ST_HELD) && !btn;
                held_d    = (state_d == ST_HELD);
            end

            assign btn_repeat[gi] = 1'b0;
`endif

            assign btn_press[gi]   = press_q;
            assign btn_release[gi] = release_q;
            assign btn_held[gi]    = held_q;
        end
    endgenerate

endmodule

// File: tb/tb_input_events.sv
// Scoreboard bench for input_events: a per-cycle behavioural model pushes expected outputs,
// a monitor pops and compares them after every rising edge.
module tb_input_events;

    localparam int HOLD   = 8;
    localparam int REPEAT = 4;
`ifdef INPUT_EVENTS_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] sw_in;
    logic [4:0] btn_in;
    logic [7:0] sw_q;
    logic       sw_changed;
    logic [4:0] btn_press;
    logic [4:0] btn_release;
    logic [4:0] btn_repeat;
    logic [4:0] btn_held;

    input_events #(
        .HOLD_CYCLES  (HOLD),
        .REPEAT_CYCLES(REPEAT),
        .CNT_W        (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sw_in      (sw_in),
        .btn_in     (btn_in),
        .sw_q       (sw_q),
        .sw_changed (sw_changed),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_repeat (btn_repeat),
        .btn_held   (btn_held)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] swq;
        logic       chg;
        logic [4:0] press;
        logic [4:0] rel;
        logic [4:0] rpt;
        logic [4:0] held;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    // Model state: a button must be seen low after reset ("armed") before it can be pressed;
    // while pressed, age counts edges since the press edge.
    bit         m_armed[5];
    bit         m_pressed[5];
    int         m_age[5];
    bit         m_primed;
    logic [7:0] m_swq;

    function automatic void chk(string name, logic [7:0] got, logic [7:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, want);
        end
    endfunction

    function automatic exp_t model_edge(logic r, logic [7:0] sw, logic [4:0] btn);
        exp_t e;
        e = '0;
        if (!r) begin
            m_primed = 1'b0;
            m_swq    = '0;
            for (int i = 0; i < 5; i++) begin
                m_armed[i]   = 1'b0;
                m_pressed[i] = 1'b0;
                m_age[i]     = 0;
            end
            return e;
        end
        e.chg    = m_primed && (sw != m_swq);
        m_swq    = sw;
        m_primed = 1'b1;
        e.swq    = sw;
        for (int i = 0; i < 5; i++) begin
            if (!m_armed[i]) begin
                if (!btn[i]) m_armed[i] = 1'b1;
            end else if (!m_pressed[i]) begin
                if (btn[i]) begin
                    e.press[i]   = 1'b1;
                    m_pressed[i] = 1'b1;
                    m_age[i]     = 0;
                end
            end else if (!btn[i]) begin
                e.rel[i]     = 1'b1;
                m_pressed[i] = 1'b0;
            end else begin
                m_age[i]++;
                if (REP_EN && (m_age[i] == HOLD ||
                    (m_age[i] > HOLD && ((m_age[i] - HOLD) % REPEAT) == 0)))
                    e.rpt[i] = 1'b1;
            end
            e.held[i] = m_pressed[i];
        end
        return e;
    endfunction

    // One clock of stimulus: drive away from the rising edge and record the expected result.
    task automatic step(input logic r, input logic [7:0] sw, input logic [4:0] btn);
        @(negedge clk);
        rst_n  = r;
        sw_in  = sw;
        btn_in = btn;
        exp_q.push_back(model_edge(r, sw, btn));
        if (!r) begin
            #1;
            chk("async_rst_outputs", {sw_q}, 8'h00);
            chk("async_rst_events", {1'b0, btn_press | btn_release | btn_repeat | btn_held | {4'b0, sw_changed}}, 8'h00);
        end
    endtask

    task automatic run(input int n, input logic [7:0] sw, input logic [4:0] btn);
        for (int i = 0; i < n; i++) step(1'b1, sw, btn);
    endtask

    // Monitor: outputs are valid every cycle, so compare once per rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sw_q",        sw_q,                e.swq);
                chk("sw_changed",  {7'b0, sw_changed},  {7'b0, e.chg});
                chk("btn_press",   {3'b0, btn_press},   {3'b0, e.press});
                chk("btn_release", {3'b0, btn_release}, {3'b0, e.rel});
                chk("btn_repeat",  {3'b0, btn_repeat},  {3'b0, e.rpt});
                chk("btn_held",    {3'b0, btn_held},    {3'b0, e.held});
            end
        end
    end

    initial begin
        logic [7:0] rsw;
        logic [4:0] rbtn;
        int         wait_cnt;

        rst_n  = 1'b0;
        sw_in  = 8'hA5;
        btn_in = 5'b00001;
        void'(model_edge(1'b0, 8'h00, 5'b0));
        #2;
        chk("reset_sw_q",   sw_q, 8'h00);
        chk("reset_events", {1'b0, btn_press | btn_held | {4'b0, sw_changed}}, 8'h00);

        // Button 0 held and switches at A5 through reset release.
        for (int i = 0; i < 3; i++) step(1'b0, 8'hA5, 5'b00001);
        run(3, 8'hA5, 5'b00001);
        run(2, 8'hA5, 5'b00000);
        run(3, 8'hA5, 5'b00001);
        run(2, 8'hA5, 5'b00000);

        // Short press on button 2.
        run(3, 8'hA5, 5'b00100);
        run(3, 8'hA5, 5'b00000);

        // Long hold on button 1: press edge plus 30 more.
        run(31, 8'hA5, 5'b00010);
        run(3, 8'hA5, 5'b00000);

        // Button 3 released exactly on its first terminal count.
        run(8, 8'hA5, 5'b01000);
        run(3, 8'hA5, 5'b00000);

        // All buttons and a switch change on the same edge.
        run(2, 8'h00, 5'b00000);
        run(3, 8'h81, 5'b11111);
        run(2, 8'h81, 5'b00000);

        // Reset while button 4 is repeating; it must be seen low again afterwards.
        run(14, 8'h81, 5'b10000);
        step(1'b0, 8'h81, 5'b10000);
        step(1'b0, 8'h81, 5'b10000);
        run(5, 8'h3C, 5'b10000);
        run(2, 8'h3C, 5'b00000);
        run(3, 8'h3C, 5'b10000);
        run(2, 8'h3C, 5'b00000);

        // Randomised: sticky button levels, occasional switch flips and resets.
        rsw  = 8'h3C;
        rbtn = 5'b0;
        for (int i = 0; i < 400; i++) begin
            for (int b = 0; b < 5; b++)
                if ($urandom_range(0, 5) == 0) rbtn[b] = ~rbtn[b];
            if ($urandom_range(0, 3) == 0) rsw = 8'($urandom);
            step(($urandom_range(0, 99) != 0), rsw, rbtn);
        end

        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        #2;
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
